// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals shared by the
// memory port arbiter and whatever drives it.
interface mem_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 8
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between fetch and load/store, with data
// priority bounded by a starvation counter, and returns one valid per access.
module mem_port_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 8,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q,      state_d;
  logic [2:0]    lat_cnt_q,    lat_cnt_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic          own_data_q,   own_data_d;
  logic          own_store_q,  own_store_d;
  logic          if_valid_q,   if_valid_d;
  logic          d_valid_q,    d_valid_d;
  logic [DW-1:0] if_rdata_q,   if_rdata_d;
  logic [DW-1:0] d_rdata_q,    d_rdata_d;

  logic          if_gnt;
  logic          d_gnt;
  logic          data_wins;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    own_data_d   = own_data_q;
    own_store_d  = own_store_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    data_wins    = 1'b0;
    m_en         = 1'b0;
    m_we         = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;

    case (state_q)
      IDLE: begin
        // Gating with rst keeps grants and memory strobes quiet while reset is held.
        if (rst) begin
          data_wins = bus.d_req && (!bus.if_req || (starve_cnt_q < 4'(STARVE_LIMIT)));
          if (data_wins) begin
            d_gnt       = 1'b1;
            m_en        = 1'b1;
            m_we        = bus.d_we;
            m_addr      = bus.d_addr;
            m_wdata     = bus.d_wdata;
            own_data_d  = 1'b1;
            own_store_d = bus.d_we;
            state_d     = BUSY;
            lat_cnt_d   = 3'(MEM_LAT);
            if (bus.if_req) starve_cnt_d = starve_cnt_q + 4'd1;
          end else if (bus.if_req) begin
            if_gnt       = 1'b1;
            m_en         = 1'b1;
            m_addr       = bus.if_addr;
            own_data_d   = 1'b0;
            own_store_d  = 1'b0;
            state_d      = BUSY;
            lat_cnt_d    = 3'(MEM_LAT);
            starve_cnt_d = 4'd0;
          end
        end
      end
      BUSY: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) begin
          state_d = IDLE;
          if (own_data_q) begin
            d_valid_d = 1'b1;
            if (!own_store_q) d_rdata_d = bus.m_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.m_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 3'd0;
      starve_cnt_q <= 4'd0;
      own_data_q   <= 1'b0;
      own_store_q  <= 1'b0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      own_data_q   <= own_data_d;
      own_store_q  <= own_store_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.if_gnt   = if_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.if_valid = if_valid_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.m_en     = m_en;
  assign bus.m_we     = m_we;
  assign bus.m_addr   = m_addr;
  assign bus.m_wdata  = m_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 at MEM_LAT=2, instance 1 at MEM_LAT=1,
// each with a behavioural memory and a timeline model checked every cycle.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]         if_req, d_req, d_we;
  logic [1:0][AW-1:0] if_addr, d_addr;
  logic [1:0][DW-1:0] d_wdata;

  logic [1:0]         o_if_gnt, o_if_valid, o_d_gnt, o_d_valid, o_m_en, o_m_we;
  logic [1:0][DW-1:0] o_if_rdata, o_d_rdata, o_m_wdata;
  logic [1:0][AW-1:0] o_m_addr;

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] init_val(input int a);
    logic [DW-1:0] v;
    if (a == 16) v = 8'h5A;
    else v = 8'(a * 7 + 3);
    return v;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got=%0h want=%0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 2 : 1;
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
    assign bus.if_req  = if_req[g];
    assign bus.if_addr = if_addr[g];
    assign bus.d_req   = d_req[g];
    assign bus.d_we    = d_we[g];
    assign bus.d_addr  = d_addr[g];
    assign bus.d_wdata = d_wdata[g];
    assign o_if_gnt[g]   = bus.if_gnt;
    assign o_if_valid[g] = bus.if_valid;
    assign o_if_rdata[g] = bus.if_rdata;
    assign o_d_gnt[g]    = bus.d_gnt;
    assign o_d_valid[g]  = bus.d_valid;
    assign o_d_rdata[g]  = bus.d_rdata;
    assign o_m_en[g]     = bus.m_en;
    assign o_m_we[g]     = bus.m_we;
    assign o_m_addr[g]   = bus.m_addr;
    assign o_m_wdata[g]  = bus.m_wdata;

    // Synchronous memory: read data emerges LAT cycles after the enable edge;
    // non-enabled cycles inject 0xEE so mistimed sampling is visible.
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] pipe [4];
    initial begin
      for (int k = 0; k < NW; k++) mem[k] = init_val(k);
      forever begin
        @(posedge clk);
        if (bus.m_en) begin
          pipe[0] <= mem[bus.m_addr];
          if (bus.m_we) mem[bus.m_addr] = bus.m_wdata;
        end else begin
          pipe[0] <= 8'hEE;
        end
        for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign bus.m_rdata = pipe[LAT-1];
  end

  // Timeline model: a grant in cycle T keeps the port busy through T+L and
  // completes in T+L+1; arbitration follows the priority/starvation rules.
  logic [DW-1:0] mmem [2][NW];
  int            cyc;
  int            busy_end [2];
  int            done_cyc [2];
  int            starve   [2];
  bit            own_d    [2];
  bit            own_st   [2];
  logic [DW-1:0] pend     [2];
  logic [DW-1:0] e_ifr    [2];
  logic [DW-1:0] e_dr     [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NW; k++) mmem[i][k] = init_val(k);
      busy_end[i] = -1; done_cyc[i] = -1; starve[i] = 0;
      own_d[i] = 1'b0; own_st[i] = 1'b0; pend[i] = '0; e_ifr[i] = '0; e_dr[i] = '0;
    end
    cyc = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int            lat;
        bit            gd, gi, ev_if, ev_d;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        lat = (i == 0) ? 2 : 1;
        gd = 1'b0; gi = 1'b0; ev_if = 1'b0; ev_d = 1'b0;
        if (!rst) begin
          busy_end[i] = -1; done_cyc[i] = -1; starve[i] = 0;
          e_ifr[i] = '0; e_dr[i] = '0;
        end else begin
          if (cyc > busy_end[i]) begin
            gd = d_req[i] && (!if_req[i] || starve[i] < 4);
            gi = if_req[i] && !gd;
          end
          if (cyc == done_cyc[i]) begin
            ev_d  = own_d[i];
            ev_if = !own_d[i];
            if (own_d[i] && !own_st[i]) e_dr[i] = pend[i];
            if (!own_d[i]) e_ifr[i] = pend[i];
          end
        end
        ea = gd ? d_addr[i] : (gi ? if_addr[i] : '0);
        ew = gd ? d_wdata[i] : '0;
        chk("if_gnt",   i, 32'(o_if_gnt[i]),   32'(gi));
        chk("d_gnt",    i, 32'(o_d_gnt[i]),    32'(gd));
        chk("m_en",     i, 32'(o_m_en[i]),     32'(gd | gi));
        chk("m_we",     i, 32'(o_m_we[i]),     32'(gd & d_we[i]));
        chk("m_addr",   i, 32'(o_m_addr[i]),   32'(ea));
        chk("m_wdata",  i, 32'(o_m_wdata[i]),  32'(ew));
        chk("if_valid", i, 32'(o_if_valid[i]), 32'(ev_if));
        chk("d_valid",  i, 32'(o_d_valid[i]),  32'(ev_d));
        chk("if_rdata", i, 32'(o_if_rdata[i]), 32'(e_ifr[i]));
        chk("d_rdata",  i, 32'(o_d_rdata[i]),  32'(e_dr[i]));
        if (gd || gi) begin
          own_d[i]    = gd;
          own_st[i]   = gd && d_we[i];
          pend[i]     = mmem[i][ea];
          if (own_st[i]) mmem[i][ea] = ew;
          busy_end[i] = cyc + lat;
          done_cyc[i] = cyc + lat + 1;
          if (gi) starve[i] = 0;
          else if (if_req[i]) starve[i] = starve[i] + 1;
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    if_req = '0; d_req = '0; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) step();
  endtask

  // Both ports requesting continuously: data wins four times, fetch once.
  task automatic starve_run(input int slots);
    for (int c = 0; c <= 3 * (slots - 1); c++) begin
      @(negedge clk);
      if (c % 3 == 0) begin
        chk("st_dgnt", 0, 32'(o_d_gnt[0]),  32'(((c / 3) % 5) != 4));
        chk("st_fgnt", 0, 32'(o_if_gnt[0]), 32'(((c / 3) % 5) == 4));
      end else begin
        chk("st_nognt", 0, 32'(o_d_gnt[0] | o_if_gnt[0]), 32'd0);
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b0;
    clr();
    if_req[0] = 1'b1; d_req[0] = 1'b1;
    @(negedge clk);
    chk("rst_gnt",  0, 32'(o_d_gnt[0] | o_if_gnt[0]), 32'd0);
    chk("rst_men",  0, 32'(o_m_en[0]),  32'd0);
    chk("rst_dval", 0, 32'(o_d_valid[0] | o_if_valid[0]), 32'd0);
    chk("rst_drd",  0, 32'(o_d_rdata[0]), 32'd0);
    step();
    clr();
    rst = 1'b1;
    idle(2);

    // Single load of 0x5A from 0x010.
    d_req[0] = 1'b1; d_addr[0] = 12'h010;
    @(negedge clk);
    chk("ld_gnt", 0, 32'(o_d_gnt[0]), 32'd1);
    chk("ld_men", 0, 32'(o_m_en[0]),  32'd1);
    step(); clr();
    @(negedge clk); chk("ld_c1", 0, 32'(o_d_valid[0]), 32'd0);
    step();
    @(negedge clk); chk("ld_c2", 0, 32'(o_d_valid[0]), 32'd0);
    step();
    @(negedge clk);
    chk("ld_c3_val", 0, 32'(o_d_valid[0]),  32'd1);
    chk("ld_c3_rd",  0, 32'(o_d_rdata[0]),  32'h5A);
    chk("ld_c3_fv",  0, 32'(o_if_valid[0]), 32'd0);
    idle(2);

    // Store 0xC3 to 0x020, then fetch the same address.
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 12'h020; d_wdata[0] = 8'hC3;
    @(negedge clk);
    chk("st_mwe", 0, 32'(o_m_we[0]), 32'd1);
    step(); clr();
    if_req[0] = 1'b1; if_addr[0] = 12'h020;
    @(negedge clk); chk("sf_c1", 0, 32'(o_if_gnt[0]), 32'd0);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    chk("sf_c3_dv",  0, 32'(o_d_valid[0]), 32'd1);
    chk("sf_c3_gnt", 0, 32'(o_if_gnt[0]),  32'd1);
    chk("sf_c3_drd", 0, 32'(o_d_rdata[0]), 32'h5A);
    step(); clr();
    step();
    step();
    @(negedge clk);
    chk("sf_c6_fv", 0, 32'(o_if_valid[0]), 32'd1);
    chk("sf_c6_rd", 0, 32'(o_if_rdata[0]), 32'hC3);
    idle(2);

    // Starvation pattern over two full rounds.
    if_req[0] = 1'b1; if_addr[0] = 12'h200;
    d_req[0]  = 1'b1; d_addr[0]  = 12'h100;
    starve_run(10);
    idle(4);

    // Fetch request withdrawn while a load is in flight.
    d_req[0] = 1'b1; d_addr[0] = 12'h011;
    @(negedge clk); chk("wd_gnt", 0, 32'(o_d_gnt[0]), 32'd1);
    step(); clr();
    if_req[0] = 1'b1; if_addr[0] = 12'h300;
    @(negedge clk); chk("wd_c1_men", 0, 32'(o_m_en[0]), 32'd0);
    step(); clr();
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      chk("wd_fgnt", 0, 32'(o_if_gnt[0]),   32'd0);
      chk("wd_men",  0, 32'(o_m_en[0]),     32'd0);
      chk("wd_fval", 0, 32'(o_if_valid[0]), 32'd0);
      step();
    end
    if_req[0] = 1'b1; if_addr[0] = 12'h201;
    d_req[0]  = 1'b1; d_addr[0]  = 12'h101;
    starve_run(5);
    idle(4);

    // Reset in the middle of a load.
    d_req[0] = 1'b1; d_addr[0] = 12'h031;
    @(negedge clk); chk("rm_gnt", 0, 32'(o_d_gnt[0]), 32'd1);
    step();
    rst = 1'b0; if_req[0] = 1'b1; d_addr[0] = 12'h032;
    @(negedge clk);
    chk("rm_gnt0", 0, 32'(o_d_gnt[0] | o_if_gnt[0]), 32'd0);
    chk("rm_men0", 0, 32'(o_m_en[0]),    32'd0);
    chk("rm_dv0",  0, 32'(o_d_valid[0]), 32'd0);
    chk("rm_frd0", 0, 32'(o_if_rdata[0]), 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rm_regnt", 0, 32'(o_d_gnt[0]),  32'd1);
    chk("rm_addr",  0, 32'(o_m_addr[0]), 32'h032);
    step(); clr();
    @(negedge clk); chk("rm_c3_dv", 0, 32'(o_d_valid[0]), 32'd0);
    step();
    @(negedge clk); chk("rm_c4_dv", 0, 32'(o_d_valid[0]), 32'd0);
    step();
    @(negedge clk);
    chk("rm_c5_dv", 0, 32'(o_d_valid[0]), 32'd1);
    chk("rm_c5_rd", 0, 32'(o_d_rdata[0]), 32'(init_val(12'h032)));
    idle(3);

    // Back-to-back fetches at MEM_LAT=1 on instance 1.
    for (int c = 0; c <= 6; c++) begin
      if_req[1]  = (c <= 4);
      if_addr[1] = 12'(c / 2);
      @(negedge clk);
      if (c % 2 == 0 && c <= 4) begin
        chk("b2b_gnt",  1, 32'(o_if_gnt[1]), 32'd1);
        chk("b2b_addr", 1, 32'(o_m_addr[1]), 32'(c / 2));
      end else begin
        chk("b2b_nognt", 1, 32'(o_if_gnt[1]), 32'd0);
      end
      if (c >= 2 && c % 2 == 0) begin
        chk("b2b_val", 1, 32'(o_if_valid[1]), 32'd1);
        chk("b2b_rd",  1, 32'(o_if_rdata[1]), 32'(init_val(c / 2 - 1)));
      end else begin
        chk("b2b_noval", 1, 32'(o_if_valid[1]), 32'd0);
      end
      step();
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port, synchronous data/instruction memory between the fetch port (PC side) and the load/store port driven by the controller's MEM_read/MEM_write decode. It arbitrates one access at a time, sequences the fixed memory read latency, and returns one registered valid/data pulse per granted access. Data accesses have priority, and a starvation counter guarantees fetch forward progress.

## Interface
- AW, 12: address width, both ports and memory.
- DW, 8: data width, both ports and memory.
- MEM_LAT, 2: memory read latency in cycles; legal 1..4.
- STARVE_LIMIT, 4: consecutive lost fetch arbitrations before fetch wins; legal 1..15.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  fetch granted this cycle.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DW  fetch data, valid with if_valid.
- d_req  in  1  data request (MEM_read | MEM_write); held with attributes until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data granted this cycle.
- d_valid  out  1  one-cycle completion pulse, loads and stores.
- d_rdata  out  DW  load data, valid with d_valid.
- m_en  out  1  memory access enable.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data, valid MEM_LAT cycles after the m_en edge.

## Operation
- States: IDLE, BUSY. A grant is issued only in IDLE.
- IDLE arbitration, combinational in the same cycle:
  - Only one request high: grant it.
  - Both high and starve_cnt < STARVE_LIMIT: grant data, starve_cnt += 1.
  - Both high and starve_cnt == STARVE_LIMIT: grant fetch.
  - Any fetch grant clears starve_cnt to 0.
  - A data grant with if_req low leaves starve_cnt unchanged.
- On a grant, in the grant cycle: the winner's gnt = 1; m_en = 1; m_addr and m_wdata come from the winner; m_we = d_we for data and 0 for fetch. Otherwise all m_* = 0.
- After a grant, go to BUSY; lat_cnt loads MEM_LAT. Each BUSY cycle decrements lat_cnt.
- Last BUSY cycle (lat_cnt == 1):
  - Capture m_rdata into the owner's rdata register. Stores do not capture; d_rdata keeps its prior value.
  - Set the owner's valid for the next cycle.
  - Return to IDLE.
- if_valid and d_valid are registered, one cycle wide, never both high.
- if_gnt and d_gnt are never both high. No grant is issued in BUSY.
- starve_cnt is 4 bits and saturates at STARVE_LIMIT.
- Requests dropped before grant are legal and leave no side effect. Attributes are sampled only in the grant cycle.

## Timing
- Reset: state = IDLE, starve_cnt = 0, lat_cnt = 0, if_valid = d_valid = 0, if_rdata = d_rdata = 0.
- During reset: all gnt = 0 and m_* = 0.
- Reset mid-access discards the in-flight transaction; no valid pulse follows.
- For a grant in cycle T:
  - BUSY spans T+1 .. T+MEM_LAT.
  - m_rdata is sampled at the end of cycle T+MEM_LAT.
  - valid is high in cycle T+MEM_LAT+1.
  - The next grant is possible in cycle T+MEM_LAT+1, the same cycle as valid.
- Throughput: one access per MEM_LAT+1 cycles. Completion latency from grant: MEM_LAT+1.
- A request that arrives while BUSY waits. It is arbitrated in the first IDLE cycle.

## Test plan
- Single load, MEM_LAT=2:
  - Stimulus: d_req=1, d_we=0, d_addr=0x010 in cycle 0; memory holds 0x5A at 0x010.
  - Required: d_gnt and m_en high in cycle 0; d_valid high in cycle 3 with d_rdata=0x5A; if_valid stays 0.
- Store then fetch of the same address:
  - Stimulus: store 0xC3 to 0x020 in cycle 0; if_req at 0x020 from cycle 1.
  - Required: m_we=1 in cycle 0; d_valid in cycle 3; if_gnt in cycle 3; if_valid in cycle 6 with if_rdata=0xC3.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: if_req and d_req held high continuously.
  - Required: four data grants, then one fetch grant, then the pattern repeats. Fetch grant cycles are 0, 3, 6, 9 for data and 12 for fetch at MEM_LAT=2. starve_cnt returns to 0 after the fetch grant.
- MEM_LAT=1 back-to-back fetches:
  - Stimulus: if_req held for 3 accesses at addresses 0, 1, 2.
  - Required: grants in cycles 0, 2, 4; if_valid in cycles 2, 4, 6 with the matching data.
- Reset mid-access:
  - Stimulus: load granted in cycle 0; rst low during cycle 1; rst released in cycle 2.
  - Required: no d_valid; all outputs 0 during reset; a new request granted in the first cycle after release.
- Request withdrawn while BUSY:
  - Stimulus: if_req raised in cycle 1 and dropped in cycle 2, during a data access.
  - Required: no if_gnt; no m_en beyond cycle 0; starve_cnt stays 0.
